// File: rtl/boot_memory_pkg.sv
// Shared types and defaults for the boot memory: FSM state encoding,
// default geometry and an address-width helper.
package boot_memory_pkg;

  localparam int DEPTH_DEFAULT = 256;
  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // A single-word memory still needs a one-bit address.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/boot_memory_if.sv
// Processor bus and byte-loader stream of the boot memory.
// The slave modport is the memory side; the master modport is the driver side.
interface boot_memory_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [AW-1:0] Mem_ADDR;
  logic [DW-1:0] Mem_IN;
  logic          write;
  logic [DW-1:0] Mem_OUT;

  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;

  modport slave (
    input  Mem_ADDR, Mem_IN, write, ld_valid, ld_data, ld_last,
    output Mem_OUT, ld_ready
  );

  modport master (
    output Mem_ADDR, Mem_IN, write, ld_valid, ld_data, ld_last,
    input  Mem_OUT, ld_ready
  );
endinterface

// File: rtl/boot_memory_ram.sv
// Storage array: one synchronous write port and one combinational read port.
// Contents have no reset; the owning FSM zeroes them explicitly.
module ram_256x8 #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/boot_memory.sv
// Boot memory: zeroes itself, takes an image from a byte loader, then serves
// the processor with an optional write-protected low region.
module boot_memory
  import boot_memory_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEFAULT,
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter int ROM_LIMIT = 0
) (
  input  logic         clk,
  input  logic         reset,
  boot_memory_if.slave bus,
  output logic         cpu_reset,
  output logic         boot_done,
  output logic         load_full,
  output logic         wr_fault
);
  localparam int            AW        = addr_width(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic [AW-1:0] ld_ptr_q, ld_ptr_d;
  logic          load_full_q, load_full_d;
  logic          wr_fault_q, wr_fault_d;

  logic             ld_accept;
  logic             rom_hit;
  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [WIDTH-1:0] ram_wdata;

  assign ld_accept = (state_q == ST_LOAD) && bus.ld_valid;
  assign rom_hit   = ($unsigned(32'(bus.Mem_ADDR)) < $unsigned(ROM_LIMIT));

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    ld_ptr_d    = ld_ptr_q;
    load_full_d = load_full_q;
    wr_fault_d  = wr_fault_q;
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_ADDR) begin
          state_d   = ST_LOAD;
          clr_ptr_d = '0;
          ld_ptr_d  = '0;
        end
      end
      ST_LOAD: begin
        if (ld_accept) begin
          ld_ptr_d = (ld_ptr_q == LAST_ADDR) ? '0 : ld_ptr_q + 1'b1;
          if (bus.ld_last) begin
            state_d = ST_RUN;
          end else if (ld_ptr_q == LAST_ADDR) begin
            // Image filled the whole array without a terminator.
            state_d     = ST_RUN;
            load_full_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (bus.write && rom_hit) begin
          wr_fault_d = 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      clr_ptr_q   <= '0;
      ld_ptr_q    <= '0;
      load_full_q <= 1'b0;
      wr_fault_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      ld_ptr_q    <= ld_ptr_d;
      load_full_q <= load_full_d;
      wr_fault_q  <= wr_fault_d;
    end
  end

  // Single write port: the FSM owns it until RUN, then the processor does.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clr_ptr_q;
    ram_wdata = '0;
    case (state_q)
      ST_CLEAR: begin
        ram_we    = !reset;
        ram_waddr = clr_ptr_q;
        ram_wdata = '0;
      end
      ST_LOAD: begin
        ram_we    = ld_accept && !reset;
        ram_waddr = ld_ptr_q;
        ram_wdata = bus.ld_data;
      end
      ST_RUN: begin
        ram_we    = bus.write && !rom_hit && !reset;
        ram_waddr = bus.Mem_ADDR;
        ram_wdata = bus.Mem_IN;
      end
      default: ram_we = 1'b0;
    endcase
  end

  ram_256x8 #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (bus.Mem_ADDR),
    .rdata_o (bus.Mem_OUT)
  );

  assign bus.ld_ready = (state_q == ST_LOAD);
  assign cpu_reset    = (state_q != ST_RUN);
  assign boot_done    = (state_q == ST_RUN);
  assign load_full    = load_full_q;
  assign wr_fault     = wr_fault_q;
endmodule

// File: tb/tb_boot_memory.sv
// Bench for boot_memory: a cycle model of the boot sequence checked on every
// falling edge, plus directed scenarios with literal expectations.
module tb_boot_memory;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cpu_reset, boot_done, load_full, wr_fault;

  boot_memory_if #(.AW(8), .DW(8)) bus ();

  boot_memory #(.DEPTH(DEPTH), .WIDTH(8), .ROM_LIMIT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .boot_done (boot_done),
    .load_full (load_full),
    .wr_fault  (wr_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0 = zeroing, 1 = taking the image, 2 = serving the processor.
  int         m_mode = 0;
  int         m_clear_left = DEPTH;
  int         m_ptr = 0;
  bit         m_full = 1'b0;
  bit         m_fault = 1'b0;
  logic [7:0] m_mem [DEPTH];

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_mode = 0; m_clear_left = DEPTH; m_ptr = 0; m_full = 1'b0; m_fault = 1'b0;
      end else if (m_mode == 0) begin
        m_clear_left--;
        if (m_clear_left == 0) begin
          foreach (m_mem[i]) m_mem[i] = 8'h00;
          m_mode = 1;
          m_ptr  = 0;
        end
      end else if (m_mode == 1) begin
        if (bus.ld_valid) begin
          m_mem[m_ptr] = bus.ld_data;
          if (bus.ld_last) m_mode = 2;
          else if (m_ptr == DEPTH - 1) begin m_mode = 2; m_full = 1'b1; end
          m_ptr = (m_ptr + 1) % DEPTH;
        end
      end else begin
        if (bus.write) begin
          if (int'(bus.Mem_ADDR) < 16) m_fault = 1'b1;
          else m_mem[bus.Mem_ADDR] = bus.Mem_IN;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("ld_ready", 32'(bus.ld_ready), 32'(m_mode == 1));
      chk("cpu_reset", 32'(cpu_reset), 32'(m_mode != 2));
      chk("boot_done", 32'(boot_done), 32'(m_mode == 2));
      chk("load_full", 32'(load_full), 32'(m_full));
      chk("wr_fault", 32'(wr_fault), 32'(m_fault));
      if (m_mode != 0) chk("mem_out", 32'(bus.Mem_OUT), 32'(m_mem[bus.Mem_ADDR]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    bus.ld_valid = 1'b1; bus.ld_data = d; bus.ld_last = last;
    tick();
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
    bus.Mem_ADDR = a;
    tick();
    chk(name, 32'(bus.Mem_OUT), 32'(exp));
    $display("read addr=0x%02h data=0x%02h", a, bus.Mem_OUT);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.ld_ready && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic reset_pulse(input string name);
    #2 reset = 1'b1;
    #1;
    chk({name, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({name, "_ld_ready"}, 32'(bus.ld_ready), 32'd0);
    chk({name, "_boot_done"}, 32'(boot_done), 32'd0);
    chk({name, "_wr_fault"}, 32'(wr_fault), 32'd0);
    chk({name, "_load_full"}, 32'(load_full), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] d;
    bus.Mem_ADDR = '0; bus.Mem_IN = '0; bus.write = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;

    #10;
    @(posedge clk);
    #1 reset = 1'b0;
    wait_ready(n);
    chk("clear_cycles", 32'(n), 32'd256);
    chk("cpu_reset_in_load", 32'(cpu_reset), 32'd1);
    $display("clear pass took %0d cycles", n);

    // Processor write during LOAD must be ignored.
    bus.write = 1'b1; bus.Mem_ADDR = 8'h20; bus.Mem_IN = 8'h77;
    tick();
    bus.write = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      bus.Mem_ADDR = 8'(a);
      tick();
      chk("clear_zero", 32'(bus.Mem_OUT), 32'h0);
    end

    send(8'hA1, 1'b0); send(8'hB2, 1'b0); send(8'hC3, 1'b1);
    chk("last_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("last_boot_done", 32'(boot_done), 32'd1);
    chk("last_load_full", 32'(load_full), 32'd0);
    rd(8'h00, 8'hA1, "img0"); rd(8'h01, 8'hB2, "img1");
    rd(8'h02, 8'hC3, "img2"); rd(8'h03, 8'h00, "img3");
    rd(8'h20, 8'h00, "load_write_ignored");
    send(8'hEE, 1'b0);
    rd(8'h03, 8'h00, "run_loader_ignored");

    // Protected write, then an unprotected one.
    bus.Mem_ADDR = 8'h05; bus.Mem_IN = 8'hFF; bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    chk("rom_unchanged", 32'(bus.Mem_OUT), 32'h00);
    chk("rom_fault", 32'(wr_fault), 32'd1);
    bus.Mem_ADDR = 8'h20; bus.Mem_IN = 8'h5A; bus.write = 1'b1;
    #1 chk("ram_before_edge", 32'(bus.Mem_OUT), 32'h00);
    tick();
    bus.write = 1'b0;
    chk("ram_after_edge", 32'(bus.Mem_OUT), 32'h5A);
    $display("rom write fault=%0b ram write data=0x%02h", wr_fault, bus.Mem_OUT);

    reset_pulse("rst_run");
    wait_ready(n);
    chk("clear_cycles_2", 32'(n), 32'd256);

    // ld_valid 1,0,0,1: only two bytes land.
    bus.ld_valid = 1'b1; bus.ld_data = 8'h11; tick();
    bus.ld_valid = 1'b0; bus.ld_data = 8'h33; tick();
    bus.ld_data = 8'h44; tick();
    bus.ld_valid = 1'b1; bus.ld_data = 8'h22; tick();
    bus.ld_valid = 1'b0;
    rd(8'h00, 8'h11, "gap0"); rd(8'h01, 8'h22, "gap1"); rd(8'h02, 8'h00, "gap2");
    for (int i = 0; i < 8; i++) send(8'h60 + 8'(i), 1'b0);
    rd(8'h09, 8'h67, "ten_loaded");

    reset_pulse("rst_load");
    wait_ready(n);
    chk("clear_cycles_3", 32'(n), 32'd256);
    for (int a = 0; a < 10; a++) rd(8'(a), 8'h00, "reload_zero");

    for (int i = 0; i < DEPTH; i++) begin
      d = 8'(i) ^ 8'h5A;
      send(d, 1'b0);
    end
    chk("full_flag", 32'(load_full), 32'd1);
    chk("full_boot_done", 32'(boot_done), 32'd1);
    bus.ld_valid = 1'b1; bus.ld_data = 8'hEE;
    #1 chk("full_no_ready", 32'(bus.ld_ready), 32'd0);
    tick();
    bus.ld_valid = 1'b0;
    rd(8'h00, 8'h5A, "full_first"); rd(8'hFF, 8'hA5, "full_last");
    chk("full_sticky", 32'(load_full), 32'd1);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/boot_memory.md
BOOT_MEMORY -- requirements
Module: boot_memory

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning the number of memory words, equal to the processor address space.
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning the data word width.
REQ-003 The block SHALL have parameter ROM_LIMIT, default 0, meaning addresses below this value are read-only in RUN (0 = no protection).
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 Mem_ADDR  input  8  processor address.
REQ-007 Mem_IN  input  8  processor write data.
REQ-008 write  input  1  processor write strobe.
REQ-009 Mem_OUT  output  8  read data at Mem_ADDR.
REQ-010 ld_valid  input  1  loader byte valid.
REQ-011 ld_data  input  8  loader byte.
REQ-012 ld_last  input  1  marks the final loader byte; qualified by ld_valid.
REQ-013 ld_ready  output  1  block accepts a loader byte.
REQ-014 cpu_reset  output  1  holds the processor in reset until the image is loaded.
REQ-015 boot_done  output  1  high in RUN.
REQ-016 load_full  output  1  sticky; the image filled all DEPTH words without ld_last.
REQ-017 wr_fault  output  1  sticky; a processor write hit a protected address.

Function
REQ-018 The FSM SHALL have states CLEAR, LOAD and RUN, and SHALL enter CLEAR on reset.
REQ-019 CLEAR SHALL write 0 to one address per cycle, from 0 to DEPTH-1, then SHALL enter LOAD with the load pointer at 0, taking exactly DEPTH cycles.
REQ-020 ld_ready SHALL be 1 only in LOAD and SHALL be a decode of the registered state.
REQ-021 A byte SHALL be accepted on the rising edge where ld_valid and ld_ready are both 1; ld_data is written to MEM[ptr] and ptr increments by 1.
REQ-022 Cycles with ld_valid low SHALL NOT advance ptr or write memory.
REQ-023 Accepting a byte with ld_last=1 SHALL move the FSM to RUN on the same edge.
REQ-024 Accepting the byte at ptr=DEPTH-1 with ld_last=0 SHALL move the FSM to RUN and set load_full; ptr wraps to 0 and no further bytes are accepted.
REQ-025 Addresses not loaded SHALL read as 0.
REQ-026 cpu_reset SHALL be 1 in CLEAR and LOAD and 0 in RUN; boot_done SHALL be the inverse of cpu_reset.
REQ-027 In RUN, write=1 at a rising edge SHALL store Mem_IN at Mem_ADDR if Mem_ADDR >= ROM_LIMIT; otherwise memory is unchanged and wr_fault sets.
REQ-028 The processor write inputs SHALL be ignored outside RUN, and ld_valid SHALL be ignored outside LOAD.
REQ-029 Mem_OUT SHALL equal MEM[Mem_ADDR] combinationally (zero-latency read) in all states; a write becomes visible after its clock edge.
REQ-030 load_full and wr_fault SHALL clear only on reset.

Reset
REQ-031 Asserting reset SHALL immediately force state=CLEAR, clear pointer=0, ptr=0, ld_ready=0, cpu_reset=1, boot_done=0, load_full=0 and wr_fault=0, with no clock required.
REQ-032 Reset asserted mid-CLEAR, mid-LOAD or in RUN SHALL abandon the operation in progress and restart the full CLEAR pass after reset is released.
REQ-033 Memory contents SHALL NOT be reset directly; only the CLEAR pass zeroes them.

Structure
REQ-034 Package boot_memory_pkg SHALL hold the state enum (CLEAR, LOAD, RUN) and the DEPTH/WIDTH default constants.
REQ-035 Sub-module ram_256x8 SHALL contain the storage array, with one synchronous write port and one asynchronous read port.
REQ-036 The write port mux SHALL select between the FSM (CLEAR/LOAD) and the processor (RUN).

Verification
REQ-037 Reset 10 ns, no loader activity -> ld_ready rises DEPTH cycles after release; every address reads 0x00; cpu_reset=1.
REQ-038 Load 0xA1, 0xB2, 0xC3 with ld_last on 0xC3 -> next cycle cpu_reset=0 and boot_done=1; MEM[0..2]=A1,B2,C3; MEM[3]=00; load_full=0.
REQ-039 Load 256 bytes with no ld_last -> RUN with load_full=1; a further ld_valid sees ld_ready=0 and MEM[0] keeps the first byte.
REQ-040 ROM_LIMIT=16, in RUN: write addr 0x05 data 0xFF -> MEM[5] unchanged and wr_fault=1; write addr 0x20 data 0x5A -> Mem_OUT=0x5A after the edge.
REQ-041 Reset asserted after 10 loaded bytes -> cpu_reset=1 and ld_ready=0 immediately; after the CLEAR pass MEM[0..9]=0x00.
REQ-042 Loader with ld_valid toggling 1,0,0,1 -> exactly two bytes are written, at addresses 0 and 1.
